// File: rtl/mem_responder_pkg.sv
// Shared definitions for mem_responder: FSM state encoding and wait-counter width.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_t;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/responder_ram.sv
// Single-port DEPTH_WORDS x 32 backing array: byte-enabled synchronous write,
// combinational read of the currently indexed word.
module responder_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-bus responder with programmable wait states in front of responder_ram.
// Optional out-of-range fault reporting is enabled by defining RESPONDER_FAULT_EN.
//
// state   | meaning
// IDLE    | waiting for mem_valid; request latched on acceptance
// WAIT    | counting down wait states; mem_valid drop aborts the request
// RESP    | one-cycle mem_ready; write committed at the edge leaving RESP
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        access_fault
);

  localparam int                    AW        = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  resp_state_t           r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0]         r_idx, w_idx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_fault, w_fault;
  logic                  w_accept, w_we, w_is_read;
  logic [31:0]           w_ram_rdata;
  logic                  w_unused_addr;

`ifdef RESPONDER_FAULT_EN
  logic [31:0] w_offset;
  // BASE_ADDR is aligned to the array size, so any set bit above the index is out of range.
  assign w_offset      = mem_addr - BASE_ADDR;
  assign w_fault       = |w_offset[31:AW+2];
  assign w_idx         = w_offset[AW+1:2];
  assign w_unused_addr = ^w_offset[1:0];
`else
  assign w_fault       = 1'b0;
  assign w_idx         = mem_addr[AW+1:2];
  assign w_unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0], BASE_ADDR};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = WAIT_LOAD;
          w_state_nxt = (WAIT_LOAD == '0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - WAIT_CNT_W'(1);
        if (!mem_valid) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt <= WAIT_CNT_W'(1)) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request fields are only consumed in WAIT/RESP, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx   <= w_idx;
      r_wdata <= mem_wdata;
      r_wstrb <= mem_wstrb;
      r_fault <= w_fault;
    end
  end

  assign w_is_read = (r_wstrb == 4'b0000);
  assign w_we      = (r_state == ST_RESP) && !w_is_read && !r_fault && !reset;

  responder_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (r_wstrb),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign mem_ready    = (r_state == ST_RESP);
  assign access_fault = mem_ready && r_fault;
  assign mem_rdata    = (mem_ready && w_is_read && !r_fault) ? w_ram_rdata : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_STATES 1, 0, 3), a vector table,
// hand-written corner sequences and random traffic against a word-array model.
module tb_mem_responder;

  localparam int NDUT  = 3;
  localparam int DEPTH = 1024;
`ifdef RESPONDER_FAULT_EN
  localparam bit FAULT_BUILD = 1'b1;
`else
  localparam bit FAULT_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [NDUT];
  logic        valid [NDUT];
  logic [31:0] addr  [NDUT];
  logic [31:0] wdata [NDUT];
  logic [3:0]  wstrb [NDUT];
  logic        ready [NDUT];
  logic [31:0] rdata [NDUT];
  logic        fault [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (32'h0),
      .WAIT_STATES (g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk          (clk),
      .reset        (rst[g]),
      .mem_valid    (valid[g]),
      .mem_addr     (addr[g]),
      .mem_wdata    (wdata[g]),
      .mem_wstrb    (wstrb[g]),
      .mem_ready    (ready[g]),
      .mem_rdata    (rdata[g]),
      .access_fault (fault[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  logic [31:0] ref_mem [NDUT][DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Model: byte-addressed array of words, index taken modulo the depth.
  task automatic ref_apply(input int k, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] exp_rd, output logic exp_f);
    int idx;
    idx    = int'((a / 4) % DEPTH);
    exp_f  = FAULT_BUILD && (a >= 32'(4 * DEPTH));
    exp_rd = 32'h0;
    if (!exp_f) begin
      if (s == 4'b0000) exp_rd = ref_mem[k][idx];
      else for (int b = 0; b < 4; b++) if (s[b]) ref_mem[k][idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Starts at posedge+1 with the DUT idle; returns one cycle after mem_ready.
  task automatic xact(input int k, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] got_rd, output logic got_f);
    int          lat;
    bit          seen, idle_bad;
    logic [31:0] exp_rd;
    logic        exp_f;
    lat = 0; seen = 1'b0; idle_bad = 1'b0;
    valid[k] = 1'b1; addr[k] = a; wdata[k] = d; wstrb[k] = s;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ready[k]) seen = 1'b1;
      else if (rdata[k] !== 32'h0 || fault[k] !== 1'b0) idle_bad = 1'b1;
    end
    got_rd = rdata[k];
    got_f  = fault[k];
    valid[k] = 1'b0; wstrb[k] = 4'b0000;
    chk($sformatf("latency dut%0d addr %h", k, a), 32'(lat), 32'(ws_of(k) + 1));
    chk($sformatf("quiet outputs before ready dut%0d", k), {31'b0, idle_bad}, 32'h0);
    ref_apply(k, a, d, s, exp_rd, exp_f);
    chk($sformatf("model rdata dut%0d addr %h", k, a), got_rd, exp_rd);
    chk($sformatf("model fault dut%0d addr %h", k, a), {31'b0, got_f}, {31'b0, exp_f});
    @(posedge clk); #1;
    chk($sformatf("ready one cycle dut%0d", k), {31'b0, ready[k]}, 32'h0);
  endtask

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    logic        exp_f;
  } vec_t;

  localparam int NVEC = 15;
  vec_t        vt [NVEC];
  logic [31:0] rd;
  logic        f;
  logic [3:0]  pat;
  bit          flag;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      rst[k] = 1'b1; valid[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("reset ready dut%0d", k), {31'b0, ready[k]}, 32'h0);
      chk($sformatf("reset rdata dut%0d", k), rdata[k], 32'h0);
      chk($sformatf("reset fault dut%0d", k), {31'b0, fault[k]}, 32'h0);
      rst[k] = 1'b0;
    end
    @(posedge clk); #1;

    vt[0]  = '{0, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    vt[1]  = '{0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{0, 32'h20,   32'h11223344, 4'hF, 32'h0, 1'b0};
    vt[3]  = '{0, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0, 1'b0};
    vt[4]  = '{0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vt[5]  = '{0, 32'h24,   32'h01020304, 4'hF, 32'h0, 1'b0};
    vt[6]  = '{0, 32'h26,   32'hA0B0C0D0, 4'h6, 32'h0, 1'b0};
    vt[7]  = '{0, 32'h24,   32'h0,        4'h0, 32'h01B0C004, 1'b0};
    vt[8]  = '{0, 32'h0,    32'h0BADF00D, 4'hF, 32'h0, 1'b0};
    vt[9]  = '{0, 32'h1000, 32'h5555AAAA, 4'hF, 32'h0, FAULT_BUILD};
    vt[10] = '{0, 32'h0,    32'h0,        4'h0, FAULT_BUILD ? 32'h0BADF00D : 32'h5555AAAA, 1'b0};
    vt[11] = '{1, 32'h8,    32'h12345678, 4'hF, 32'h0, 1'b0};
    vt[12] = '{1, 32'h8,    32'h0,        4'h0, 32'h12345678, 1'b0};
    vt[13] = '{2, 32'hC,    32'h87654321, 4'hF, 32'h0, 1'b0};
    vt[14] = '{2, 32'hF,    32'h0,        4'h0, 32'h87654321, 1'b0};
    for (int i = 0; i < NVEC; i++) begin
      xact(vt[i].k, vt[i].a, vt[i].d, vt[i].s, rd, f);
      chk($sformatf("vector %0d rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vector %0d fault", i), {31'b0, f}, {31'b0, vt[i].exp_f});
    end

    // WAIT_STATES=0 with mem_valid held: ready in cycles 1 and 3, bubble in 2.
    valid[1] = 1'b1; addr[1] = 32'h8; wstrb[1] = 4'h0;
    pat = '0; flag = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      pat[c] = ready[1];
      if (ready[1] && rdata[1] !== 32'h12345678) flag = 1'b1;
      if (c == 2) valid[1] = 1'b0;
    end
    chk("ws0 back-to-back ready pattern", {28'b0, pat}, 32'h5);
    chk("ws0 back-to-back rdata", {31'b0, flag}, 32'h0);

    // Reset while in RESP of a write: write must be dropped.
    xact(0, 32'h30, 32'h13579BDF, 4'hF, rd, f);
    valid[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hFFFFFFFF; wstrb[0] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ws1 reached RESP before reset", {31'b0, ready[0]}, 32'h1);
    rst[0] = 1'b1; valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("ready after reset in RESP", {31'b0, ready[0]}, 32'h0);
    rst[0] = 1'b0;
    xact(0, 32'h30, 32'h0, 4'h0, rd, f);
    chk("word kept after reset in RESP", rd, 32'h13579BDF);

    // Reset during WAIT of a write to 0x40 (WAIT_STATES=3).
    xact(2, 32'h40, 32'h2468ACE0, 4'hF, rd, f);
    valid[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'hFFFF0000; wstrb[2] = 4'hF;
    @(posedge clk); #1;
    rst[2] = 1'b1; valid[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    flag = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (ready[2]) flag = 1'b1;
      @(posedge clk); #1;
    end
    chk("no ready after reset in WAIT", {31'b0, flag}, 32'h0);
    xact(2, 32'h40, 32'h0, 4'h0, rd, f);
    chk("word kept after reset in WAIT", rd, 32'h2468ACE0);

    // mem_valid dropped in WAIT: abort, back to IDLE, no write.
    xact(2, 32'h44, 32'h0F0F0F0F, 4'hF, rd, f);
    valid[2] = 1'b1; addr[2] = 32'h44; wdata[2] = 32'hF0F0F0F0; wstrb[2] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid[2] = 1'b0; wstrb[2] = 4'h0;
    @(posedge clk); #1;
    chk("no ready after valid drop", {31'b0, ready[2]}, 32'h0);
    xact(2, 32'h44, 32'h0, 4'h0, rd, f);
    chk("word kept after valid drop", rd, 32'h0F0F0F0F);

    // Random traffic over 16 words plus their aliases above the array.
    for (int k = 0; k < NDUT; k++) begin
      for (int w = 0; w < 16; w++) xact(k, 32'(w * 4), $urandom, 4'hF, rd, f);
      for (int n = 0; n < 30; n++) begin
        logic [31:0] a;
        logic [3:0]  s;
        a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
        s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        xact(k, a, $urandom, s, rd, f);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
